// File: rtl/dot_matrix_pkg.sv
// dot_matrix_pkg: cell codes and glyph lookup shared by the dot-matrix board scanner.
package dot_matrix_pkg;
   typedef logic [1:0] cell_t;
   localparam cell_t CELL_EMPTY = 2'd0;
   localparam cell_t CELL_X     = 2'd1;
   localparam cell_t CELL_O     = 2'd2;
   localparam cell_t CELL_WIN   = 2'd3;
   // X = both diagonals, O = border without corners, WIN = all on
   function automatic logic glyph_bit(input cell_t code, input int px, input int py, input int n);
      return code == CELL_X ? (px == py || px + py == n - 1)
           : code == CELL_O ? ((px == 0 || px == n - 1) != (py == 0 || py == n - 1))
           : code == CELL_WIN;
   endfunction
endpackage

// File: rtl/dot_matrix_board_scanner_row.sv
// dot_row_scanner: row dwell counter, one-hot row rotation, blank window and frame_done.
module dot_row_scanner #(
   parameter int DIV   = 12500,
   parameter int ROWS  = 10,
   parameter int BLANK = 16
)(
   input  logic            clk,
   input  logic            rst,
   output logic [ROWS-1:0] dot_row,
   output logic [ROWS-1:0] row_nxt,
   output logic            blank_nxt,
   output logic            frame_done
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt, cnt_nxt;
   logic tick;
   always_comb begin
      tick = cnt == CW'(DIV - 1);
      cnt_nxt = tick ? '0 : cnt + 1'b1;
      row_nxt = tick ? {dot_row[ROWS-2:0], dot_row[ROWS-1]} : dot_row;
      blank_nxt = cnt_nxt < CW'(BLANK);
      frame_done = tick && dot_row[ROWS-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         dot_row <= ROWS'(1);
      end else begin
         cnt <= cnt_nxt;
         dot_row <= row_nxt;
      end
endmodule

// File: rtl/dot_matrix_board_scanner.sv
// dot_matrix_board_scanner: double-buffered GRID x GRID board renderer for an LED dot matrix.
// Define CURSOR_BLINK_EN to add a blinking cursor cell (cursor_en, cursor ports).
module dot_matrix_board_scanner
   import dot_matrix_pkg::*;
#(
   parameter int DIV   = 12500,
   parameter int ROWS  = 10,
   parameter int COLS  = 14,
   parameter int GRID  = 3,
   parameter int CELL  = 3,
   parameter int GAP   = 1,
   parameter int BLANK = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*GRID*GRID-1:0] board,
   input  logic                   board_valid,
`ifdef CURSOR_BLINK_EN
   input  logic                   cursor_en,
   input  logic [$clog2(GRID*GRID)-1:0] cursor,
`endif
   output logic                   board_ready,
   output logic [ROWS-1:0]        dot_row,
   output logic [COLS-1:0]        dot_col,
   output logic                   frame_done
);
   localparam int P = CELL + GAP;
   // the bottom glyph row may be clipped by the matrix edge, so the 10-row default still fits
   if (GRID * P - GAP > COLS || (GRID - 1) * P >= ROWS || BLANK >= DIV) begin : g_bad_cfg
      $error("dot_matrix_board_scanner: board does not fit the matrix or BLANK >= DIV");
   end
   logic [2*GRID*GRID-1:0] active, pending, act_nxt;
   logic full, capture, swap, blank_nxt;
   logic [ROWS-1:0] row_nxt;
   logic [COLS-1:0] pat;
   cell_t code;
   int idx;

   dot_row_scanner #(.DIV(DIV), .ROWS(ROWS), .BLANK(BLANK)) u_scan (
      .clk(clk),
      .rst(rst),
      .dot_row(dot_row),
      .row_nxt(row_nxt),
      .blank_nxt(blank_nxt),
      .frame_done(frame_done)
   );

   assign board_ready = !full;
   assign capture = board_valid && !full;
   assign swap = frame_done && full;
   assign act_nxt = swap ? pending : active;

`ifdef CURSOR_BLINK_EN
   logic [4:0] fcnt;
   logic phase, cur_on;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fcnt <= '0;
         phase <= 1'b0;
      end else if (frame_done) begin
         fcnt <= fcnt + 1'b1;
         phase <= phase ^ (&fcnt);
      end
   assign cur_on = cursor_en && (phase ^ (frame_done && &fcnt));
`endif

   // pattern is built for the row and buffer that will be live next cycle, keeping dot_col registered
   always_comb begin
      pat = '0;
      code = CELL_EMPTY;
      idx = 0;
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++)
            if (row_nxt[y] && y / P < GRID && x / P < GRID && y % P < CELL && x % P < CELL) begin
               idx = (y / P) * GRID + x / P;
               code = cell_t'(act_nxt[2*idx +: 2]);
`ifdef CURSOR_BLINK_EN
               if (cur_on && idx == int'(cursor)) code = (code == CELL_EMPTY) ? CELL_WIN : CELL_EMPTY;
`endif
               pat[x] = glyph_bit(code, x % P, y % P, CELL);
            end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         active <= '0;
         pending <= '0;
         full <= 1'b0;
         dot_col <= '0;
      end else begin
         active <= act_nxt;
         if (capture) pending <= board;
         full <= capture || (full && !swap);
         dot_col <= blank_nxt ? '0 : pat;
      end
endmodule

// File: tb/tb_dot_matrix_board_scanner.sv
// tb_dot_matrix_board_scanner: directed checks of scan timing, glyphs, handshake and frame swaps.
module tb_dot_matrix_board_scanner;
   localparam logic [17:0] BRD_A = 18'h10001;
   localparam logic [17:0] BRD_B = 18'h20302;
   localparam logic [17:0] BRD_C = 18'h00100;
   logic clk = 1'b0, rst = 1'b1, board_valid = 1'b0;
   logic [17:0] board = '0;
   logic board_ready, frame_done;
   logic [9:0] dot_row;
   logic [13:0] dot_col;
   int n_checks = 0, n_fail = 0, fd_cnt;
`ifdef CURSOR_BLINK_EN
   logic cursor_en = 1'b0;
   logic [3:0] cursor = '0;
`endif

   dot_matrix_board_scanner #(.DIV(4), .BLANK(1)) dut (
      .clk(clk),
      .rst(rst),
      .board(board),
      .board_valid(board_valid),
`ifdef CURSOR_BLINK_EN
      .cursor_en(cursor_en),
      .cursor(cursor),
`endif
      .board_ready(board_ready),
      .dot_row(dot_row),
      .dot_col(dot_col),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // returns in the first cycle of row y, i.e. inside the blank window
   task automatic goto_row(input int y);
      logic [9:0] prev;
      prev = dot_row;
      for (int n = 0; n < 100; n++) begin
         step(1);
         if (dot_row != prev && dot_row == 10'(1 << y)) return;
         prev = dot_row;
      end
      check("goto_row", dot_row, 1 << y);
   endtask

   task automatic sample_row(input int y);
      goto_row(y);
      check("blank", dot_col, 0);
      step(1);
   endtask

   initial begin
      #12;
      check("rst_row", dot_row, 1);
      check("rst_col", dot_col, 0);
      check("rst_ready", board_ready, 1);
      check("rst_fd", frame_done, 0);
      rst = 1'b0;
      fd_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         if (frame_done) fd_cnt++;
         if (k % 4 == 0) check("row_seq", dot_row, 1 << ((k / 4) % 10));
      end
      check("fd_per_frame", fd_cnt, 1);
      board = BRD_A;
      board_valid = 1'b1;
      step(1);
      board_valid = 1'b0;
      check("a_taken", board_ready, 0);
      check("old_r0", dot_col, 0);
      sample_row(0);
      check("a_r0", dot_col, 14'h005);
      check("ready_after_swap", board_ready, 1);
      sample_row(1);
      check("a_r1", dot_col, 14'h002);
      sample_row(3);
      check("a_r3_gap", dot_col, 0);
      sample_row(5);
      board = BRD_B;
      board_valid = 1'b1;
      step(1);
      check("b_taken", board_ready, 0);
      board = BRD_C;
      step(8);
      board_valid = 1'b0;
      sample_row(8);
      check("a_r8_hold", dot_col, 14'h500);
      check("ready_low", board_ready, 0);
      sample_row(0);
      check("b_r0", dot_col, 14'h002);
      sample_row(4);
      check("b_r4", dot_col, 14'h070);
      sample_row(5);
      check("b_r5", dot_col, 14'h070);
      check("c_ignored", board_ready, 1);
      goto_row(9);
      step(3);
      check("fd_tick", frame_done, 1);
      board = BRD_C;
      board_valid = 1'b1;
      step(1);
      board_valid = 1'b0;
      check("c_on_swap", board_ready, 0);
      step(1);
      check("b_kept_r0", dot_col, 14'h002);
      sample_row(5);
      check("b_kept_r5", dot_col, 14'h070);
      sample_row(0);
      check("c_r0", dot_col, 0);
      sample_row(5);
      check("c_r5", dot_col, 14'h020);
      check("c_ready", board_ready, 1);
      board = BRD_A;
      board_valid = 1'b1;
      step(1);
      board_valid = 1'b0;
      check("a_pending", board_ready, 0);
      sample_row(6);
      check("c_r6", dot_col, 14'h050);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_row", dot_row, 1);
      check("mid_rst_col", dot_col, 0);
      check("mid_rst_ready", board_ready, 1);
      #3 rst = 1'b0;
      sample_row(0);
      check("zero_r0", dot_col, 0);
      check("zero_ready", board_ready, 1);
      sample_row(8);
      check("zero_r8", dot_col, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
